// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: state encoding, idle level, baud divider.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_tx_buffered_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
`else
    ST_STOP   = 3'd3
`endif
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with full/empty/count and a sticky overflow flag.
// Head byte is visible on rd_data_o without a read request (show-ahead).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if ((DEPTH < 2) || (DEPTH != (1 << AW))) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2 equal to 2**AW");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  assign full_o     = (count_q == FULL_COUNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    // A dropped push is flagged even when a pop frees a slot in the same cycle.
    overflow_d = overflow_q | (wr_en_i & full_o);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser with internal baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          overflow,
  output logic          txd
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_buffered: DIV must be at least 2");
  end

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          pop, load;
  logic          cnt_expired;
  logic [7:0]    fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  assign busy        = (state_q != ST_IDLE);
  assign txd         = txd_q;
  assign cnt_expired = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        txd_d = TX_IDLE_LEVEL;
        load  = !empty;
      end
      ST_START: begin
        if (cnt_expired) begin
          cnt_d     = CNT_RELOAD;
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_expired) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = ST_PARITY;
`else
            txd_d   = TX_IDLE_LEVEL;
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_expired) begin
          cnt_d   = CNT_RELOAD;
          txd_d   = TX_IDLE_LEVEL;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_expired) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = TX_IDLE_LEVEL;
      end
    endcase

    if (load) begin
      shift_d = fifo_rd_data;
      cnt_d   = CNT_RELOAD;
      txd_d   = ~TX_IDLE_LEVEL;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rd_data;
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= TX_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level model compared every cycle plus directed literal checks.
// Honours UART_TX_PARITY_EN for the 11-bit frame.
module tb_uart_tx_buffered;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, busy, overflow, txd;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .CLK_FREQ (16),
    .BAUD     (4),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .overflow (overflow),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: a queue of bytes and the frame in flight, indexed by elapsed clocks.
  logic [7:0]    mq[$];
  bit            m_in_frame = 1'b0;
  int            m_elapsed = 0;
  logic [NB-1:0] m_frame = '1;
  bit            m_ovf = 1'b0;

  function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
    logic [NB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic model_step();
    int pre;
    if (!rst) begin
      mq.delete();
      m_in_frame = 1'b0;
      m_elapsed  = 0;
      m_ovf      = 1'b0;
    end else begin
      pre = mq.size();
      if (m_in_frame) begin
        m_elapsed++;
        if (m_elapsed == NB * DIV) m_in_frame = 1'b0;
      end
      if (!m_in_frame && pre > 0) begin
        m_frame    = frame_of(mq.pop_front());
        m_in_frame = 1'b1;
        m_elapsed  = 0;
      end
      if (wr_en) begin
        if (pre == DEPTH) m_ovf = 1'b1;
        else mq.push_back(wr_data);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_txd", {31'd0, txd}, m_in_frame ? {31'd0, m_frame[m_elapsed / DIV]} : 32'd1);
      check("model_busy", {31'd0, busy}, {31'd0, m_in_frame});
      check("model_count", {29'd0, count}, mq.size());
      check("model_full", {31'd0, full}, (mq.size() == DEPTH) ? 32'd1 : 32'd0);
      check("model_empty", {31'd0, empty}, (mq.size() == 0) ? 32'd1 : 32'd0);
      check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // Tasks below start and end 1 time unit after a rising edge.
  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    $display("push %02h at %0t", b, $time);
  endtask

  logic seq [0:511];

  // Records txd on each falling edge while busy; returns busy length in clocks.
  task automatic capture(input bit wait_edge, output int len);
    len = 0;
    if (wait_edge) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 300 && busy; k++) begin
      seq[k] = txd;
      len++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_txd"}, {31'd0, txd}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_count"}, {29'd0, count}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    logic [NB-1:0] lit;
    int            len;
    int            bad;

    #2 rst = 1'b0;
    #1 check_reset_values("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1 LSB first, [parity 0], stop.
`ifdef UART_TX_PARITY_EN
    lit = 11'h54A;
`else
    lit = 10'h34A;
`endif
    push(8'hA5);
    @(posedge clk);
    for (int i = 0; i < NB * DIV; i++) begin
      @(negedge clk);
      check("a5_txd", {31'd0, txd}, {31'd0, lit[i / DIV]});
      check("a5_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    check("a5_busy_end", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back; second push coincides with the first pop.
    push(8'h55);
    push(8'h0F);
    @(negedge clk);
    check("pushpop_count", {29'd0, count}, 32'd1);
    @(posedge clk);
    #1;
    capture(1'b0, len);
    check("b2b_len", len, 2 * NB * DIV - 1);
    check("b2b_stop1", {31'd0, seq[NB * DIV - 2]}, 32'd1);
    check("b2b_start2", {31'd0, seq[NB * DIV - 1]}, 32'd0);
    check("b2b_bit0_2", {31'd0, seq[NB * DIV - 1 + DIV]}, 32'd1);
    wait_idle(20);

    // Overflow while the serialiser is busy.
    push(8'h11);
    @(posedge clk);
    #1;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    push(8'h24);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_count4", {29'd0, count}, 32'd4);
    check("ovf_pre", {31'd0, overflow}, 32'd0);
    push(8'h99);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {29'd0, count}, 32'd4);
    wait_idle(6 * NB * DIV);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_drained", {29'd0, count}, 32'd0);

    // Parity-position bit for 0x07 and 0x03 (stop bit when parity is absent).
    push(8'h07);
    capture(1'b1, len);
    check("b07_len", len, NB * DIV);
    check("b07_bit9", {31'd0, seq[9 * DIV]}, 32'd1);
    push(8'h03);
    capture(1'b1, len);
    check("b03_len", len, NB * DIV);
`ifdef UART_TX_PARITY_EN
    check("b03_bit9", {31'd0, seq[9 * DIV]}, 32'd0);
`else
    check("b03_bit9", {31'd0, seq[9 * DIV]}, 32'd1);
`endif

    // Reset mid-frame with a queued byte and a sticky overflow.
    push(8'h3C);
    push(8'hC3);
    push(8'h01);
    push(8'h02);
    push(8'h04);
    push(8'h08);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_values("midreset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_frame_after_reset", bad, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
